// File: rtl/seg_pkg.sv
// Shared constants, state type and helpers for the seven-segment scan controller.
package seg_pkg;

  localparam int unsigned DIGIT_NUM = 6;

  // Active-low patterns {dp,g,f,e,d,c,b,a}; the decimal point is always off here.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {
    StIdle,
    StScan
  } state_e;

  // True when digit k (k > 0) and every digit above it hold code 0.
  function automatic logic is_leading_zero(input logic [23:0] d, input logic [2:0] k);
    logic zero;
    zero = (k != 3'd0);
    for (int i = 0; i < int'(DIGIT_NUM); i++) begin
      if (i >= int'(k) && d[4*i +: 4] != 4'h0) begin
        zero = 1'b0;
      end
    end
    return zero;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational BCD to seven-segment decoder (active-low, no decimal point).
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] pattern
);

  // Blank flag wins; 0-9 are digits, A is a dash, B-F are dark.
  always_comb begin
    pattern = SEG_BLANK[6:0];
    if (!blank) begin
      unique case (code)
        4'h0:    pattern = SEG_0[6:0];
        4'h1:    pattern = SEG_1[6:0];
        4'h2:    pattern = SEG_2[6:0];
        4'h3:    pattern = SEG_3[6:0];
        4'h4:    pattern = SEG_4[6:0];
        4'h5:    pattern = SEG_5[6:0];
        4'h6:    pattern = SEG_6[6:0];
        4'h7:    pattern = SEG_7[6:0];
        4'h8:    pattern = SEG_8[6:0];
        4'h9:    pattern = SEG_9[6:0];
        4'hA:    pattern = SEG_DASH[6:0];
        default: pattern = SEG_BLANK[6:0];
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed seven-segment scan controller with per-frame input snapshot.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter logic [15:0] CNT_MAX = 16'd49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        en,
  input  logic [23:0] data,
  input  logic [5:0]  point,
  input  logic        lz_blank,
  output logic [5:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_start
);

  state_e      state;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [23:0] snap_data;
  logic [5:0]  snap_point;
  logic        snap_lz;

  logic [3:0]  cur_code;
  logic        cur_blank;
  logic        cur_dp_n;
  logic [6:0]  cur_pattern;

  // Select the snapshot digit addressed by the current index.
  always_comb begin
    cur_code  = snap_data[4*idx +: 4];
    cur_blank = snap_lz && is_leading_zero(snap_data, idx);
    cur_dp_n  = ~snap_point[idx];
  end

  seg_decode u_decode (
    .code    (cur_code),
    .blank   (cur_blank),
    .pattern (cur_pattern)
  );

  // Scan FSM: dwell counter, digit index, snapshot and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= StIdle;
      cnt         <= '0;
      idx         <= '0;
      snap_data   <= '0;
      snap_point  <= '0;
      snap_lz     <= 1'b0;
      sel         <= '0;
      seg         <= SEG_BLANK;
      frame_start <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          sel <= '0;
          seg <= SEG_BLANK;
          cnt <= '0;
          idx <= '0;
          if (en) begin
            state       <= StScan;
            snap_data   <= data;
            snap_point  <= point;
            snap_lz     <= lz_blank;
            frame_start <= 1'b1;
          end else begin
            frame_start <= 1'b0;
          end
        end
        StScan: begin
          if (!en) begin
            state       <= StIdle;
            sel         <= '0;
            seg         <= SEG_BLANK;
            cnt         <= '0;
            idx         <= '0;
            frame_start <= 1'b0;
          end else begin
            // Outputs follow the index one clock later, so they hold a full dwell.
            sel <= 6'b000001 << idx;
            seg <= {cur_dp_n, cur_pattern};
            if (cnt == CNT_MAX) begin
              cnt <= '0;
              if (idx == 3'(DIGIT_NUM - 1)) begin
                idx         <= '0;
                snap_data   <= data;
                snap_point  <= point;
                snap_lz     <= lz_blank;
                frame_start <= 1'b1;
              end else begin
                idx         <= idx + 3'd1;
                frame_start <= 1'b0;
              end
            end else begin
              cnt         <= cnt + 16'd1;
              frame_start <= 1'b0;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a short dwell.
module tb_seg_scan_ctrl;

  localparam logic [15:0] CNT_MAX = 16'd3;
  localparam int DWELL = int'(CNT_MAX) + 1;
  localparam int FRAME = DWELL * 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [23:0] data = '0;
  logic [5:0]  point = '0;
  logic        lz_blank = 1'b0;
  logic [5:0]  sel;
  logic [7:0]  seg;
  logic        frame_start;

  int errors = 0;
  int checks = 0;

  seg_scan_ctrl #(.CNT_MAX(CNT_MAX)) dut (
    .sys_clk     (clk),
    .sys_rst_n   (rst_n),
    .en          (en),
    .data        (data),
    .point       (point),
    .lz_blank    (lz_blank),
    .sel         (sel),
    .seg         (seg),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Glyph for one digit from the rules: value lookup, leading-zero test by shifting.
  function automatic logic [7:0] ref_seg(input logic [23:0] d, input logic [5:0] p,
                                         input logic l, input int k);
    int upper;
    int code;
    logic [7:0] pat;
    upper = int'(d) >> (4 * k);
    code  = upper & 15;
    case (code)
      0: pat = 8'hC0;  1: pat = 8'hF9;  2: pat = 8'hA4;  3: pat = 8'hB0;
      4: pat = 8'h99;  5: pat = 8'h92;  6: pat = 8'h82;  7: pat = 8'hF8;
      8: pat = 8'h80;  9: pat = 8'h90;  10: pat = 8'hBF;
      default: pat = 8'hFF;
    endcase
    if (l && k > 0 && upper == 0) pat = 8'hFF;
    pat[7] = ~p[k];
    return pat;
  endfunction

  // Reference model: n counts edges since enable; digit and frame follow from n.
  logic        m_act;
  int          m_n;
  logic [23:0] m_sd;
  logic [5:0]  m_sp;
  logic        m_sl;
  logic [5:0]  exp_sel;
  logic [7:0]  exp_seg;
  logic        exp_fs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0; m_n <= 0; m_sd <= '0; m_sp <= '0; m_sl <= 1'b0;
      exp_sel <= '0; exp_seg <= 8'hFF; exp_fs <= 1'b0;
    end else if (!m_act) begin
      exp_sel <= '0;
      exp_seg <= 8'hFF;
      exp_fs  <= en;
      if (en) begin
        m_act <= 1'b1; m_n <= 0; m_sd <= data; m_sp <= point; m_sl <= lz_blank;
      end
    end else if (!en) begin
      m_act <= 1'b0; exp_sel <= '0; exp_seg <= 8'hFF; exp_fs <= 1'b0;
    end else begin
      m_n     <= m_n + 1;
      exp_sel <= 6'(1 << ((m_n / DWELL) % 6));
      exp_seg <= ref_seg(m_sd, m_sp, m_sl, (m_n / DWELL) % 6);
      exp_fs  <= ((m_n + 1) % FRAME == 0);
      if ((m_n + 1) % FRAME == 0) begin
        m_sd <= data; m_sp <= point; m_sl <= lz_blank;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Advance to the next falling edge and compare against the model.
  task automatic tick();
    @(negedge clk);
    chk("model_sel", 32'(sel), 32'(exp_sel));
    chk("model_seg", 32'(seg), 32'(exp_seg));
    chk("model_fs", 32'(frame_start), 32'(exp_fs));
  endtask

  // Drop to idle, load inputs, enable; returns right after the frame_start edge.
  task automatic start(input logic [23:0] d, input logic [5:0] p, input logic l);
    en = 1'b0;
    tick();
    data = d; point = p; lz_blank = l; en = 1'b1;
    tick();
    chk("start_fs", 32'(frame_start), 32'd1);
  endtask

  typedef struct {
    logic [23:0] data;
    logic [5:0]  point;
    logic        lz;
    logic [47:0] segs;  // digit k at segs[8k +: 8]
  } vec_t;

  vec_t vecs[9];
  int   fs_cnt;

  initial begin
    vecs[0] = '{24'h123456, 6'b000000, 1'b0, 48'hF9A4B0999282};
    vecs[1] = '{24'h000120, 6'b000000, 1'b1, 48'hFFFFFFF9A4C0};
    vecs[2] = '{24'h000000, 6'b000000, 1'b1, 48'hFFFFFFFFFFC0};
    vecs[3] = '{24'h000000, 6'b000000, 1'b0, 48'hC0C0C0C0C0C0};
    vecs[4] = '{24'h000A00, 6'b000100, 1'b0, 48'hC0C0C03FC0C0};
    vecs[5] = '{24'h00C000, 6'b001000, 1'b0, 48'hC0C07FC0C0C0};
    vecs[6] = '{24'h000005, 6'b100000, 1'b1, 48'h7FFFFFFFFF92};
    vecs[7] = '{24'h987078, 6'b000000, 1'b1, 48'h9080F8C0F880};
    vecs[8] = '{24'h0B0003, 6'b000000, 1'b1, 48'hFFFFC0C0C0B0};

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_fs", 32'(frame_start), 32'd0);

    // Release with en already high: frame_start on first edge, digit 0 on the next
    en = 1'b1; data = 24'h123456;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_fs", 32'(frame_start), 32'd1);
    chk("rel_sel0", 32'(sel), 32'd0);
    tick();
    chk("rel_sel1", 32'(sel), 32'h01);
    chk("rel_seg", 32'(seg), 32'h82);
    chk("rel_fs2", 32'(frame_start), 32'd0);

    // Table-driven static frames
    foreach (vecs[v]) begin
      start(vecs[v].data, vecs[v].point, vecs[v].lz);
      for (int k = 0; k < 6; k++) begin
        for (int j = 0; j < DWELL; j++) begin
          tick();
          if (j == 0) begin
            chk("vec_sel", 32'(sel), 32'(6'b000001 << k));
            chk("vec_seg", 32'(seg), 32'(vecs[v].segs[8*k +: 8]));
          end
        end
      end
    end

    // Mid-frame data change waits for the next frame
    start(24'h123456, 6'b0, 1'b0);
    for (int i = 1; i <= FRAME; i++) begin
      tick();
      if (i == 10) data = 24'h654321;
      if (i == 12) chk("mid_old_seg", 32'(seg), 32'h99);
      if (i == FRAME) begin
        chk("mid_fs", 32'(frame_start), 32'd1);
        chk("mid_last_seg", 32'(seg), 32'hF9);
      end
    end
    tick();
    chk("mid_new_sel", 32'(sel), 32'h01);
    chk("mid_new_seg", 32'(seg), 32'hF9);
    fs_cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      if (frame_start) fs_cnt++;
    end
    chk("fs_per_frame", 32'(fs_cnt), 32'd2);

    // Enable dropped at digit 3, then raised again
    start(24'h123456, 6'b0, 1'b0);
    for (int i = 0; i < 14; i++) tick();
    chk("drop_sel3", 32'(sel), 32'h08);
    en = 1'b0;
    tick();
    chk("drop_sel", 32'(sel), 32'd0);
    chk("drop_seg", 32'(seg), 32'hFF);
    en = 1'b1;
    tick();
    chk("reen_fs", 32'(frame_start), 32'd1);
    tick();
    chk("reen_sel", 32'(sel), 32'h01);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) en = ~en;
      if ($urandom_range(0, 9) == 0) begin
        data = 24'($urandom) & (24'hFFFFFF >> (4 * $urandom_range(0, 6)));
        point = 6'($urandom);
        lz_blank = 1'($urandom);
      end
      tick();
    end

    // Asynchronous reset mid-dwell acts without a clock edge
    start(24'h888888, 6'b111111, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_seg", 32'(seg), 32'hFF);
    chk("arst_fs", 32'(frame_start), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
